uart_tx_dev: RTL and testbench

Memory-mapped UART transmitter that sits on the SoC bus as a device-side responder, alongside the RAM, console and CLINT slots. The core writes bytes into a small TX FIFO through the bus device port. An 8N1 serializer drains the FIFO onto a single serial line. It gives FPGA builds a physical character output path, where the console device only logs to a file.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_tx_dev_if.sv | 36 +++
 rtl/uart_tx_dev_sync_fifo.sv | 78 +++++++
 rtl/uart_tx_dev.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter (and a future
// receiver): bus widths, register word offsets, STATUS bit positions, the
// serializer state encoding, the 8N1 frame length and the divisor helper.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int DIV_WIDTH  = 16;

    // Register select, decoded from addr[3:2] (byte offsets 0x0/0x4/0x8/0xC).
    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_DIV    = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_e;

    // STATUS register layout.
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_LEVEL_LSB = 4;
    localparam int STAT_LEVEL_W   = 5;

    // Serializer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // 8N1: one start bit, eight data bits, one stop bit.
    localparam int FRAME_BITS = 10;

    // A programmed divisor of zero behaves as one clock per bit.
    function automatic logic [DIV_WIDTH-1:0] eff_div(input logic [DIV_WIDTH-1:0] div);
        logic [DIV_WIDTH-1:0] res;
        if (div == 16'd0) begin
            res = 16'd1;
        end else begin
            res = div;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_dev_if.sv
// ----------------------------------------------------------------------------
// uart_tx_dev_if
// Device-side bus port of the UART transmitter. One-cycle qualified access,
// no grant/wait states; read data comes back registered one cycle later.
//   req   : access qualifier
//   we    : 1 = write, 0 = read
//   addr  : byte address (device decodes addr[3:2])
//   wdata : write data
//   rdata : registered read data
// master modport: bus side (core/interconnect); slave modport: the device.
// ----------------------------------------------------------------------------
interface uart_tx_dev_if import uart_pkg::*; ;

    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/uart_tx_dev_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. data_o always presents the oldest entry.
// A push while full is ignored and a pop while empty is ignored; both use the
// state before the edge, so a pop on the same edge does not make room for a
// push into a full FIFO.
//   clk_i   : clock
//   rst_i   : asynchronous active-low reset (empties the FIFO)
//   push_i  : write data_i
//   pop_i   : discard the head entry
//   data_i  : write data
//   data_o  : head entry
//   full_o  : FIFO holds DEPTH entries
//   empty_o : FIFO holds no entries
//   level_o : number of entries held
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_push_ok;
    logic w_pop_ok;

    assign full_o    = (r_level == LW'(DEPTH));
    assign empty_o   = (r_level == LW'(0));
    assign level_o   = r_level;
    assign data_o    = r_mem[r_rd_ptr];
    assign w_push_ok = push_i & ~full_o;
    assign w_pop_ok  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// ----------------------------------------------------------------------------
// uart_tx_dev
// Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA are queued in
// a TX FIFO and shifted out LSB first on tx_o, divisor clocks per bit.
//   clk_i : system clock
//   rst_i : asynchronous active-low reset
//   bus   : device port (req/we/addr/wdata in, registered rdata out)
//   tx_o  : serial output, idles high, driven from a flop
//   irq_o : registered level interrupt: FIFO empty, serializer idle, IRQ_EN
// Registers (byte offsets): 0x0 TXDATA (W), 0x4 STATUS (R, write clears
// overflow), 0x8 DIV (RW [15:0]), 0xC CTRL (RW bit0 IRQ_EN).
// ----------------------------------------------------------------------------
module uart_tx_dev import uart_pkg::*; #(
    parameter int                   FIFO_DEPTH  = 8,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd868
) (
    input  logic         clk_i,
    input  logic         rst_i,
    uart_tx_dev_if.slave bus,
    output logic         tx_o,
    output logic         irq_o
);

    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int DATA_BITS = FRAME_BITS - 2;

    // Bus decode
    logic     w_rd;
    logic     w_wr;
    reg_sel_e w_sel;

    // FIFO hookup
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_fifo_data;
    logic [LVL_W-1:0] w_level;

    // Configuration / status registers
    logic [DIV_WIDTH-1:0]  r_div_cfg;
    logic                  r_irq_en;
    logic                  r_ovf;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_irq;

    // Serializer
    tx_state_e            r_state;
    logic [7:0]           r_shift;
    logic [DIV_WIDTH-1:0] r_div_lat;
    logic [DIV_WIDTH-1:0] r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic                 r_tx;

    logic                  w_baud_done;
    logic                  w_tx_next;
    logic [DATA_WIDTH-1:0] w_status;
    logic                  w_unused_bits;

    assign w_rd   = bus.req & ~bus.we;
    assign w_wr   = bus.req & bus.we;
    assign w_sel  = reg_sel_e'(bus.addr[3:2]);
    assign w_push = w_wr & (w_sel == REG_TXDATA);

    assign w_unused_bits = ^{bus.addr[ADDR_WIDTH-1:4], bus.addr[1:0], bus.wdata[DATA_WIDTH-1:16]};

    assign w_baud_done = (r_baud_cnt == (r_div_lat - 16'd1));

    assign bus.rdata = r_rdata;
    assign tx_o      = r_tx;
    assign irq_o     = r_irq;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (bus.wdata[7:0]),
        .data_o  (w_fifo_data),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

    // Pop when idle, or at the end of a stop bit so frames run back to back.
    always_comb begin
        w_pop = 1'b0;
        if (w_empty) begin
            w_pop = 1'b0;
        end else if (r_state == IDLE) begin
            w_pop = 1'b1;
        end else if ((r_state == STOP) && w_baud_done) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
    end

    // Line level for the current state; registered below, which puts the
    // first start-bit clock one edge after the pop.
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            IDLE:    w_tx_next = 1'b1;
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_shift[0];
            STOP:    w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    // STATUS word assembly.
    always_comb begin
        w_status = {DATA_WIDTH{1'b0}};
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BUSY]  = (r_state != IDLE);
        w_status[STAT_OVF]   = r_ovf;
        w_status[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(w_level);
    end

    // Register writes: divisor, IRQ enable, sticky overflow.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div_cfg <= DEFAULT_DIV;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_wr) begin
            case (w_sel)
                REG_TXDATA: begin
                    // Full is judged before any same-edge pop.
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end
                end
                REG_STATUS: r_ovf     <= 1'b0;
                REG_DIV:    r_div_cfg <= bus.wdata[DIV_WIDTH-1:0];
                REG_CTRL:   r_irq_en  <= bus.wdata[0];
                default:    r_ovf     <= r_ovf;
            endcase
        end
    end

    // Registered read data; holds between reads.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (w_rd) begin
            case (w_sel)
                REG_TXDATA: r_rdata <= {DATA_WIDTH{1'b0}};
                REG_STATUS: r_rdata <= w_status;
                REG_DIV:    r_rdata <= {{(DATA_WIDTH-DIV_WIDTH){1'b0}}, r_div_cfg};
                REG_CTRL:   r_rdata <= {{(DATA_WIDTH-1){1'b0}}, r_irq_en};
                default:    r_rdata <= {DATA_WIDTH{1'b0}};
            endcase
        end
    end

    // Interrupt level, one cycle behind its condition.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & w_empty & (r_state == IDLE);
        end
    end

    // Serializer FSM with baud counter; divisor is latched per frame so a
    // DIV write mid-frame only affects the next frame.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_shift    <= 8'd0;
            r_div_lat  <= 16'd1;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_fifo_data;
                        r_div_lat  <= eff_div(r_div_cfg);
                        r_baud_cnt <= 16'd0;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= 16'd0;
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= 16'd0;
                        r_shift    <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= 16'd0;
                        if (w_pop) begin
                            r_shift   <= w_fifo_data;
                            r_div_lat <= eff_div(r_div_cfg);
                            r_bit_cnt <= 3'd0;
                            r_state   <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_dev
// Self-checking bench for uart_tx_dev. Bytes sent are pushed with their
// effective divisor onto a scoreboard queue; a line monitor decodes each
// frame from tx_o and compares it against the popped entry.
// ----------------------------------------------------------------------------
module tb_uart_tx_dev;

    typedef struct packed {
        logic [15:0] div;
        logic [7:0]  data;
    } frame_t;

    logic clk;
    logic rst_n;
    logic tx;
    logic irq;

    int n_checks = 0;
    int n_pass   = 0;

    frame_t exp_q[$];
    logic   mon_en   = 1'b1;
    logic   mon_busy = 1'b0;

    uart_tx_dev_if bus ();

    uart_tx_dev #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus),
        .tx_o  (tx),
        .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = {28'd0, a};
        bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = {28'd0, a};
        @(negedge clk);
        bus.req = 1'b0;
        d = bus.rdata;
    endtask

    task automatic send(input logic [7:0] b, input logic [15:0] div_eff);
        frame_t f;
        f.div  = div_eff;
        f.data = b;
        exp_q.push_back(f);
        bus_write(4'h0, {24'd0, b});
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(n >= bound), 32'd0);
    endtask

    // Line monitor: decode frames from tx at negedges, verify every sample.
    initial begin : monitor
        frame_t     f;
        logic [9:0] exp_bits;
        logic [9:0] obs_bits;
        logic       glitch;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && (tx == 1'b0)) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    f        = exp_q.pop_front();
                    exp_bits = {1'b1, f.data, 1'b0};
                    obs_bits = 10'd0;
                    glitch   = 1'b0;
                    for (int b = 0; b < 10; b++) begin
                        for (int c = 0; c < int'(f.div); c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (c == 0) obs_bits[b] = tx;
                            else if (tx !== obs_bits[b]) glitch = 1'b1;
                        end
                    end
                    check_eq("frame_bits", 32'(obs_bits), 32'(exp_bits));
                    check_eq("frame_stable", 32'(glitch), 32'd0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        logic [31:0] rd;
        int          cnt;
        logic        low_seen;

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_irq", 32'(irq), 32'd0);
        check_eq("reset_rdata", bus.rdata, 32'd0);
        bus_read(4'h4, rd);
        check_eq("reset_status", rd, 32'h002);
        bus_read(4'h8, rd);
        check_eq("reset_div", rd, 32'd868);

        // Single byte, DIV=4, latency E -> E+2
        bus_write(4'h8, 32'd4);
        bus_read(4'h8, rd);
        check_eq("div_rb4", rd, 32'd4);
        send(8'hA5, 16'd4);
        @(negedge clk);
        check_eq("lat_e1_high", 32'(tx), 32'd1);
        @(negedge clk);
        check_eq("lat_e2_low", 32'(tx), 32'd0);
        wait_drain(100);
        bus_read(4'h4, rd);
        check_eq("single_status_idle", rd, 32'h002);

        // Overflow: 10 back-to-back writes, first pops, 8 held, 10th dropped
        bus_write(4'h8, 32'd100);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) send(8'h10 + 8'(i), 16'd100);
            else bus_write(4'h0, 32'h19);
        end
        bus_read(4'h4, rd);
        check_eq("ovf_status", rd, 32'h08D);
        bus_write(4'h4, 32'hFFFF_FFFF);
        bus_read(4'h4, rd);
        check_eq("ovf_cleared", rd, 32'h085);
        wait_drain(12000);
        repeat (2) @(negedge clk);
        bus_read(4'h4, rd);
        check_eq("ovf_drained_status", rd, 32'h002);

        // Divisor 0 behaves as 1
        bus_write(4'h8, 32'd0);
        bus_read(4'h8, rd);
        check_eq("div_rb0", rd, 32'd0);
        send(8'hFF, 16'd1);
        wait_drain(100);

        // DIV change mid-frame: current frame keeps 8, next uses 2
        bus_write(4'h8, 32'd8);
        send(8'h3C, 16'd8);
        repeat (20) @(negedge clk);
        bus_write(4'h8, 32'd2);
        send(8'h5A, 16'd2);
        wait_drain(300);
        bus_read(4'h8, rd);
        check_eq("div_rb2", rd, 32'd2);

        // Interrupt
        bus_write(4'h8, 32'd4);
        bus_write(4'hC, 32'd1);
        @(negedge clk);
        check_eq("irq_en_idle", 32'(irq), 32'd1);
        bus_read(4'hC, rd);
        check_eq("ctrl_rb", rd, 32'd1);
        send(8'h81, 16'd4);
        send(8'h7E, 16'd4);
        check_eq("irq_low_busy", 32'(irq), 32'd0);
        cnt = 0;
        while (irq !== 1'b1 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("irq_rise_cycles", 32'(cnt), 32'd81);
        wait_drain(100);
        bus_write(4'hC, 32'd0);
        check_eq("irq_hold_one", 32'(irq), 32'd1);
        @(negedge clk);
        check_eq("irq_dropped", 32'(irq), 32'd0);

        // Reset mid-frame
        mon_en = 1'b0;
        bus_write(4'h0, 32'h00);
        repeat (10) @(negedge clk);
        check_eq("pre_reset_low", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_tx", 32'(tx), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        low_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        check_eq("no_residual_frame", 32'(low_seen), 32'd0);
        bus_read(4'h4, rd);
        check_eq("post_reset_status", rd, 32'h002);
        bus_read(4'h8, rd);
        check_eq("post_reset_div", rd, 32'd868);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
